// File: rtl/econet_pkg.sv
// Shared Econet definitions: scheduler state encoding, register bit positions
// and configuration reset defaults.
package econet_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_TX      = 2'd2;
  localparam logic [1:0] ST_BACKOFF = 2'd3;

  // Lane 0 command/control bits
  localparam int BIT_START  = 0;
  localparam int BIT_ABORT  = 1;
  localparam int BIT_IRQ_EN = 2;
  localparam int BIT_CLEAR  = 3;

  // Status readback bits
  localparam int BIT_BUSY   = 31;
  localparam int BIT_FAIL   = 30;
  localparam int BIT_DONE   = 29;
  localparam int BIT_COLDET = 28;

  localparam logic [7:0] IDLE_BITS_DEFAULT   = 8'd15;
  localparam logic [3:0] MAX_RETRIES_DEFAULT = 4'd7;

endpackage

// File: rtl/econet_sync.sv
// N-stage flip-flop synchroniser for a single asynchronous level.
module econet_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/econet_txsched.sv
// Econet transmit access scheduler: idle-line deferral, transmitter gating,
// collision backoff with bounded retries and a level completion interrupt.
module econet_txsched
  import econet_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  wr,
  input  logic        select,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        econet_clk,
  input  logic        line_idle,
  input  logic        collision_detect,
  input  logic        tx_done,
  output logic        tx_enable,
  output logic        txsched_interrupt
);

  logic       eclk_s, idle_s, coll_s;
  logic       eclk_d;
  logic       eclk_rise;
  logic [1:0] state;
  logic [7:0] idle_cnt;
  logic [8:0] bo_cnt;
  logic [3:0] retry_cnt;
  logic [15:0] lfsr;
  logic       lfsr_fb;
  logic       irq_en, done, fail, coldet;
  logic [7:0] idle_bits;
  logic [3:0] max_retries;
  logic       wr_en, start_cmd, abort_cmd, clear_cmd;
  logic [3:0] retry_inc;
  logic [7:0] bo_mask;
  logic [8:0] bo_load;
  logic       unused_bits;

  econet_sync #(.STAGES(SYNC_STAGES)) u_sync_eclk (
    .clk(clk), .reset(reset), .d(econet_clk), .q(eclk_s)
  );
  econet_sync #(.STAGES(SYNC_STAGES)) u_sync_idle (
    .clk(clk), .reset(reset), .d(line_idle), .q(idle_s)
  );
  econet_sync #(.STAGES(SYNC_STAGES)) u_sync_coll (
    .clk(clk), .reset(reset), .d(collision_detect), .q(coll_s)
  );

  assign eclk_rise = eclk_s & ~eclk_d;

  assign wr_en     = select & (|wr);
  assign start_cmd = wr_en & wr[0] & data_in[BIT_START];
  assign abort_cmd = wr_en & wr[0] & data_in[BIT_ABORT];
  assign clear_cmd = wr_en & wr[0] & data_in[BIT_CLEAR];

  // Fibonacci taps 16,14,13,11 on a left-shifting register
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  assign retry_inc = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;
  assign bo_mask   = (retry_inc >= 4'd8) ? 8'hFF : (8'd1 << retry_inc[2:0]) - 8'd1;
  assign bo_load   = {1'b0, lfsr[7:0] & bo_mask} + 9'd1;

  assign unused_bits = ^{wr[3], data_in[31:20], data_in[7:4]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eclk_d      <= 1'b0;
      state       <= ST_IDLE;
      idle_cnt    <= 8'd0;
      bo_cnt      <= 9'd0;
      retry_cnt   <= 4'd0;
      lfsr        <= LFSR_SEED;
      irq_en      <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      coldet      <= 1'b0;
      idle_bits   <= IDLE_BITS_DEFAULT;
      max_retries <= MAX_RETRIES_DEFAULT;
    end else begin
      eclk_d <= eclk_s;
      lfsr   <= {lfsr[14:0], lfsr_fb};

      if (wr_en && wr[0]) irq_en      <= data_in[BIT_IRQ_EN];
      if (wr_en && wr[1]) idle_bits   <= data_in[15:8];
      if (wr_en && wr[2]) max_retries <= data_in[19:16];

      // Clear is applied first so any flag set later in this cycle wins
      if (clear_cmd) begin
        done   <= 1'b0;
        fail   <= 1'b0;
        coldet <= 1'b0;
      end
      if (coll_s) coldet <= 1'b1;

      if (abort_cmd) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_cmd) begin
              retry_cnt <= 4'd0;
              idle_cnt  <= 8'd0;
              state     <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (!idle_s || coll_s) begin
              idle_cnt <= 8'd0;
            end else if (eclk_rise && idle_cnt != 8'hFF) begin
              idle_cnt <= idle_cnt + 8'd1;
            end
            if (idle_s && idle_cnt >= idle_bits) state <= ST_TX;
          end
          ST_TX: begin
            if (coll_s) begin
              retry_cnt <= retry_inc;
              if (retry_inc > max_retries) begin
                fail  <= 1'b1;
                state <= ST_IDLE;
              end else begin
                bo_cnt <= bo_load;
                state  <= ST_BACKOFF;
              end
            end else if (tx_done) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          ST_BACKOFF: begin
            if (bo_cnt == 9'd0) begin
              idle_cnt <= 8'd0;
              state    <= ST_WAIT;
            end else if (eclk_rise) begin
              bo_cnt <= bo_cnt - 9'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Gate is decoded straight from the state register so reset drops it at once
  assign tx_enable         = (state == ST_TX);
  assign txsched_interrupt = irq_en & (done | fail | coldet);

  always_comb begin
    data_out             = 32'd0;
    data_out[BIT_BUSY]   = (state != ST_IDLE);
    data_out[BIT_FAIL]   = fail;
    data_out[BIT_DONE]   = done;
    data_out[BIT_COLDET] = coldet;
    data_out[27:24]      = retry_cnt;
    data_out[19:16]      = max_retries;
    data_out[15:8]       = idle_bits;
    data_out[BIT_IRQ_EN] = irq_en;
  end

endmodule

// File: tb/tb_econet_txsched.sv
// Directed self-checking bench for econet_txsched: one task per scenario.
module tb_econet_txsched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  wr = 4'd0;
  logic        select = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        econet_clk = 1'b0;
  logic        line_idle = 1'b0;
  logic        collision_detect = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_enable;
  logic        txsched_interrupt;

  int errors = 0;
  int checks = 0;

  econet_txsched #(.LFSR_SEED(16'hACE1), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .wr(wr), .select(select), .data_in(data_in),
    .data_out(data_out), .econet_clk(econet_clk), .line_idle(line_idle),
    .collision_detect(collision_detect), .tx_done(tx_done),
    .tx_enable(tx_enable), .txsched_interrupt(txsched_interrupt)
  );

  always #5 clk = ~clk;

  task automatic write_reg(input logic [3:0] lanes, input logic [31:0] val);
    @(negedge clk);
    select = 1'b1; wr = lanes; data_in = val;
    @(negedge clk);
    select = 1'b0; wr = 4'd0; data_in = 32'd0;
    $display("write lanes=%b data=%h -> data_out=%h", lanes, val, data_out);
  endtask

  task automatic eclk_edge();
    @(negedge clk);
    econet_clk = 1'b1;
    repeat (4) @(negedge clk);
    econet_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) eclk_edge();
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // Raise collision, hold it for SYNC_STAGES+1 clocks, then wait out the synchroniser
  task automatic collide(output logic te_after);
    @(negedge clk);
    collision_detect = 1'b1;
    repeat (3) @(negedge clk);
    te_after = tx_enable;
    collision_detect = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (data_out !== 32'h0007_0F00) begin
      errors++; $display("FAIL reset_readback got=%h expected=%h", data_out, 32'h0007_0F00);
    end
    checks++;
    if (tx_enable !== 1'b0) begin
      errors++; $display("FAIL reset_tx_enable got=%b expected=0", tx_enable);
    end
    checks++;
    if (txsched_interrupt !== 1'b0) begin
      errors++; $display("FAIL reset_irq got=%b expected=0", txsched_interrupt);
    end
    reset = 1'b0;
    @(negedge clk);
    $display("reset: data_out=%h tx_enable=%b irq=%b", data_out, tx_enable, txsched_interrupt);
  endtask

  task automatic test_clean_send();
    line_idle = 1'b1;
    write_reg(4'b0111, 32'h0007_0404);
    checks++;
    if (data_out !== 32'h0007_0404) begin
      errors++; $display("FAIL config_readback got=%h expected=%h", data_out, 32'h0007_0404);
    end
    write_reg(4'b0001, 32'h0000_0005);
    checks++;
    if (data_out[31] !== 1'b1) begin
      errors++; $display("FAIL start_busy got=%b expected=1", data_out[31]);
    end
    edges(3);
    checks++;
    if (tx_enable !== 1'b0) begin
      errors++; $display("FAIL clean_early_tx got=%b expected=0", tx_enable);
    end
    edges(1);
    checks++;
    if (tx_enable !== 1'b1) begin
      errors++; $display("FAIL clean_tx_on got=%b expected=1", tx_enable);
    end
    pulse_tx_done();
    checks++;
    if (tx_enable !== 1'b0) begin
      errors++; $display("FAIL done_tx_off got=%b expected=0", tx_enable);
    end
    checks++;
    if (data_out[31:28] !== 4'b0010) begin
      errors++; $display("FAIL done_flags got=%b expected=0010", data_out[31:28]);
    end
    checks++;
    if (txsched_interrupt !== 1'b1) begin
      errors++; $display("FAIL done_irq got=%b expected=1", txsched_interrupt);
    end
    write_reg(4'b0001, 32'h0000_000C);
    checks++;
    if (data_out[29] !== 1'b0 || txsched_interrupt !== 1'b0) begin
      errors++; $display("FAIL done_clear got done=%b irq=%b expected 0/0", data_out[29], txsched_interrupt);
    end
    $display("clean_send: data_out=%h", data_out);
  endtask

  task automatic test_idle_restart();
    write_reg(4'b0001, 32'h0000_0005);
    edges(3);
    line_idle = 1'b0;
    repeat (4) @(negedge clk);
    line_idle = 1'b1;
    repeat (4) @(negedge clk);
    edges(3);
    checks++;
    if (tx_enable !== 1'b0) begin
      errors++; $display("FAIL restart_early_tx got=%b expected=0", tx_enable);
    end
    edges(1);
    checks++;
    if (tx_enable !== 1'b1) begin
      errors++; $display("FAIL restart_tx_on got=%b expected=1", tx_enable);
    end
    pulse_tx_done();
    write_reg(4'b0001, 32'h0000_000C);
    $display("idle_restart: data_out=%h", data_out);
  endtask

  task automatic test_single_retry();
    logic te;
    int n;
    write_reg(4'b0100, 32'h0002_0000);
    write_reg(4'b0001, 32'h0000_0005);
    edges(4);
    collide(te);
    checks++;
    if (te !== 1'b0) begin
      errors++; $display("FAIL retry_tx_off got=%b expected=0", te);
    end
    checks++;
    if (data_out[31:24] !== 8'b1001_0001) begin
      errors++; $display("FAIL retry_status got=%b expected=10010001", data_out[31:24]);
    end
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      eclk_edge();
      if (tx_enable === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n < 5 || n > 6) begin
      errors++; $display("FAIL retry_edges got=%0d expected=5..6", n);
    end
    pulse_tx_done();
    checks++;
    if (data_out[31:28] !== 4'b0011 || data_out[27:24] !== 4'd1) begin
      errors++; $display("FAIL retry_done got=%h expected flags=3 retry=1", data_out[31:24]);
    end
    write_reg(4'b0001, 32'h0000_000C);
    $display("single_retry: edges=%0d data_out=%h", n, data_out);
  endtask

  task automatic test_retry_exhaust();
    logic te;
    write_reg(4'b0100, 32'h0000_0000);
    write_reg(4'b0001, 32'h0000_0005);
    edges(4);
    collide(te);
    checks++;
    if (te !== 1'b0) begin
      errors++; $display("FAIL exhaust_tx_off got=%b expected=0", te);
    end
    checks++;
    if (data_out[31:24] !== 8'b0101_0001) begin
      errors++; $display("FAIL exhaust_status got=%b expected=01010001", data_out[31:24]);
    end
    checks++;
    if (txsched_interrupt !== 1'b1) begin
      errors++; $display("FAIL exhaust_irq got=%b expected=1", txsched_interrupt);
    end
    write_reg(4'b0001, 32'h0000_000C);
    checks++;
    if (data_out[30] !== 1'b0 || data_out[28] !== 1'b0) begin
      errors++; $display("FAIL exhaust_clear got fail=%b coldet=%b expected 0/0", data_out[30], data_out[28]);
    end
    checks++;
    if (txsched_interrupt !== 1'b0) begin
      errors++; $display("FAIL exhaust_clear_irq got=%b expected=0", txsched_interrupt);
    end
    $display("retry_exhaust: data_out=%h", data_out);
  endtask

  task automatic test_priority();
    logic te;
    write_reg(4'b0100, 32'h0002_0000);
    write_reg(4'b0001, 32'h0000_0005);
    edges(4);
    collide(te);
    write_reg(4'b0001, 32'h0000_0005);
    checks++;
    if (data_out[31] !== 1'b1 || data_out[27:24] !== 4'd1) begin
      errors++; $display("FAIL busy_start got busy=%b retry=%0d expected 1/1", data_out[31], data_out[27:24]);
    end
    write_reg(4'b0001, 32'h0000_0006);
    checks++;
    if (data_out[31:24] !== 8'b0001_0001) begin
      errors++; $display("FAIL abort_backoff got=%b expected=00010001", data_out[31:24]);
    end
    write_reg(4'b0001, 32'h0000_0007);
    checks++;
    if (data_out[31] !== 1'b0) begin
      errors++; $display("FAIL abort_start got busy=%b expected=0", data_out[31]);
    end
    write_reg(4'b0001, 32'h0000_000C);
    write_reg(4'b0001, 32'h0000_0005);
    edges(4);
    @(negedge clk);
    collision_detect = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    collision_detect = 1'b0;
    checks++;
    if (data_out[31:24] !== 8'b1001_0001 || tx_enable !== 1'b0) begin
      errors++; $display("FAIL coll_vs_done got=%b tx=%b expected=10010001 tx=0", data_out[31:24], tx_enable);
    end
    repeat (3) @(negedge clk);
    write_reg(4'b0001, 32'h0000_000E);
    $display("priority: data_out=%h", data_out);
  endtask

  task automatic test_async_reset();
    write_reg(4'b0001, 32'h0000_0005);
    edges(4);
    checks++;
    if (tx_enable !== 1'b1) begin
      errors++; $display("FAIL areset_pre_tx got=%b expected=1", tx_enable);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tx_enable !== 1'b0) begin
      errors++; $display("FAIL areset_tx_off got=%b expected=0", tx_enable);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (data_out !== 32'h0007_0F00) begin
      errors++; $display("FAIL areset_readback got=%h expected=%h", data_out, 32'h0007_0F00);
    end
    $display("async_reset: tx_enable=%b data_out=%h", tx_enable, data_out);
  endtask

  initial begin
    test_reset();
    test_clean_send();
    test_idle_restart();
    test_single_retry();
    test_retry_exhaust();
    test_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/econet_txsched.md
# econet_txsched

Econet transmit access scheduler. Sits between the CPU bus and the ADLC transmit path, beside the Econet hardware-control register. On CPU request it waits for a programmable run of idle line clocks, gates the ADLC transmitter on, and handles collisions: it aborts, waits a pseudo-random backoff, retries up to a limit, and raises a level interrupt on completion or failure.

## Interface
- `LFSR_SEED`, 16'hACE1: backoff LFSR reset value; must be non-zero.
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronisers.

- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `wr`  in  4: byte-lane write strobes.
- `select`  in  1: register select; a write happens when `select` is high and `wr` is non-zero.
- `data_in`  in  32: write data.
- `data_out`  out  32: status/config readback, combinational from registers.
- `econet_clk`  in  1: Econet line clock, asynchronous to `clk`; synchronised internally.
- `line_idle`  in  1: ADLC/receiver line-idle indication, asynchronous; synchronised internally.
- `collision_detect`  in  1: raw collision detector output, asynchronous; synchronised internally.
- `tx_done`  in  1: one-`clk` pulse from the ADLC at end of frame, synchronous to `clk`.
- `tx_enable`  out  1: transmitter gate to the ADLC/line driver.
- `txsched_interrupt`  out  1: level interrupt.

## Operation
- **Writes, lane 0:**
  - `data_in[0]` start: a one-shot, ignored while busy.
  - `data_in[1]` abort: one-shot.
  - `data_in[2]` `irq_en`: stored.
  - `data_in[3]` clear: one-shot, clears done/fail/coldet.
- **Writes, other lanes:**
  - Lane 1: `idle_bits[7:0]` = `data_in[15:8]`.
  - Lane 2: `max_retries[3:0]` = `data_in[19:16]`.
- **`data_out` bit map:**
  - [31] busy; [30] fail; [29] done; [28] coldet.
  - [27:24] `retry_cnt`; [23:20] 0; [19:16] `max_retries`.
  - [15:8] `idle_bits`; [7:3] 0; [2] `irq_en`; [1:0] 0.
- **Edge detect:** `econet_clk` rising edge is detected on the synchronised signal and yields a one-`clk` `eclk_rise` strobe.
- **State machine (states IDLE, WAIT_IDLE, TX, BACKOFF):**
  - IDLE: on start, clear `retry_cnt` and `idle_cnt`, then go to WAIT_IDLE.
  - WAIT_IDLE:
    - If synchronised `line_idle` is low, or a synchronised collision is seen, set `idle_cnt`=0.
    - Otherwise increment `idle_cnt` on `eclk_rise`, saturating at 255.
    - When `line_idle` is high and `idle_cnt` >= `idle_bits`, go to TX.
  - TX: `tx_enable`=1.
    - Synchronised collision: increment `retry_cnt` and set coldet.
      - If the new `retry_cnt` > `max_retries`: set fail and go to IDLE.
      - Otherwise load `bo_cnt` = (`lfsr[7:0]` & mask) + 1 and go to BACKOFF. mask = 2^`retry_cnt`−1, saturating at 8'hFF; `bo_cnt` is 9 bits.
    - `tx_done` without a collision: set done and go to IDLE.
  - BACKOFF: decrement `bo_cnt` on `eclk_rise`. At 0, clear `idle_cnt` and go to WAIT_IDLE.
- **Abort:** from any state, go to IDLE. `tx_enable` drops the next cycle. No flags change.
- **Collision outside TX:** sets coldet only; in WAIT_IDLE it also restarts the idle count.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. Free-runs every `clk` from `LFSR_SEED`.
- **Interrupt:** `txsched_interrupt` = `irq_en` & (done | fail | coldet).
- **busy** = (state != IDLE).

## Timing
- **Reset values:**
  - `tx_enable`=0, `txsched_interrupt`=0, state IDLE.
  - `irq_en`=0, done/fail/coldet=0, `retry_cnt`=0.
  - `idle_bits`=15, `max_retries`=7, `lfsr`=`LFSR_SEED`.
  - `data_out`=32'h0007_0F00.
- **Start:** a write in cycle N makes busy read 1 from N+1.
- **Defer met:** `tx_enable` rises one `clk` after the state register registers the defer condition.
- **Collision latency:** the raw `collision_detect` edge reaches `tx_enable`=0 within `SYNC_STAGES`+1 `clk`.
- **`tx_done` in cycle N:** `tx_enable`=0 and done=1 in N+1.
- **Simultaneous events:**
  - Collision and `tx_done` in the same cycle: the collision wins.
  - Abort and start in the same write: abort wins, result IDLE.
  - Clear and a new flag event in the same cycle: the set wins.
- **Boundary cases:**
  - `idle_bits`=0: TX is entered as soon as `line_idle` is high.
  - `max_retries`=0: the first collision fails.
  - `retry_cnt` saturates at 15.
- **Reset mid-TX:** `tx_enable` falls asynchronously.

## Structure
- Shared econet package holds:
  - the state encoding (2-bit);
  - the register bit positions;
  - the reset defaults (`idle_bits`=15, `max_retries`=7).
- One sub-module, `econet_sync`, is natural: an N-stage synchroniser parameterised by `SYNC_STAGES`, instanced three times (`econet_clk`, `line_idle`, `collision_detect`).
- The LFSR stays inline.

## Test plan
- **Reset readback:** reset, then read → 32'h0007_0F00, `tx_enable`=0, interrupt 0.
- **Clean send:** `idle_bits`=4, `line_idle`=1, start → `tx_enable` high after 4 `econet_clk` edges (+sync). Then pulse `tx_done` → `tx_enable` 0 next cycle, done=1, busy=0. With `irq_en`=1, the interrupt is high.
- **Idle restart:** drop `line_idle` after 3 of 4 idle edges → the count restarts and TX comes only after 4 further consecutive idle edges.
- **Single retry:** collision during TX with `max_retries`=2 → `tx_enable` 0 within 3 `clk`, `retry_cnt`=1, coldet=1. Backoff is 1–2 `econet_clk` edges, then WAIT_IDLE and TX again. A following `tx_done` gives done=1.
- **Retry exhaustion:** `max_retries`=0 and a collision in TX → fail=1, busy=0, `retry_cnt`=1. Write clear (bit3) → fail/coldet return to 0 and the interrupt deasserts.
- **Priority and re-entry:** abort during BACKOFF → IDLE, flags unchanged. Start while busy is ignored (`retry_cnt` unchanged). Collision plus `tx_done` in the same cycle → BACKOFF, not done.
